spike_network: RTL and testbench

Network-side counterpart of the per-neuron spike handshake. Collects the 2-bit spike codes from all neurons once every active neuron requests a network phase (en_network high). Selects one firing neuron by round-robin scan. Broadcasts {code, id} to all neurons as their spike input and pulses networkDone to release them into their receive phase.

---
 rtl/spike_network_pkg.sv | 18 +
 rtl/spike_network_ready_reducer.sv | 20 ++
 rtl/spike_network.sv | 112 +++++++++++
 tb/tb_spike_network.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/spike_network_pkg.sv
// Shared constants for the neuron/network spike handshake: code values, bus widths and FSM encoding.
package spike_network_pkg;

  localparam int SPK_CODE_W     = 2;
  localparam int SPK_ID_W       = 9;
  localparam int SPIKE_IN_WIDTH = SPK_CODE_W + SPK_ID_W;

  localparam logic [SPK_CODE_W-1:0] SPK_NONE = 2'd0;
  localparam logic [SPK_CODE_W-1:0] SPK_POS  = 2'd1;
  localparam logic [SPK_CODE_W-1:0] SPK_NEG  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } net_state_e;

endpackage

// File: rtl/spike_network_ready_reducer.sv
// Masked AND of per-neuron en_network requests; only indices below active_neuron take part.
module ready_reducer #(
  parameter int NUM_NEURON      = 512,
  parameter int NEURON_ID_WIDTH = 9
) (
  input  logic [NUM_NEURON-1:0]      en_network_vec_i,
  input  logic [NEURON_ID_WIDTH-1:0] active_neuron_i,
  output logic                       all_ready_o
);

  always_comb begin
    all_ready_o = 1'b1;
    for (int i = 0; i < NUM_NEURON; i++) begin
      if ((i < int'(active_neuron_i)) && !en_network_vec_i[i]) begin
        all_ready_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/spike_network.sv
// Network-side spike arbiter: waits for all active neurons, round-robin scans for one firing
// neuron, broadcasts {code, id} and pulses networkDone to release the neurons.
module spike_network
  import spike_network_pkg::*;
#(
  parameter int TEN_DATA_WIDTH  = SPK_CODE_W,
  parameter int NUM_NEURON      = 512,
  parameter int NEURON_ID_WIDTH = SPK_ID_W
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      en,
  input  logic [NEURON_ID_WIDTH-1:0]                active_neuron,
  input  logic [NUM_NEURON-1:0]                     en_network_vec,
  input  logic [TEN_DATA_WIDTH*NUM_NEURON-1:0]      spike_vec,
  output logic [TEN_DATA_WIDTH+NEURON_ID_WIDTH-1:0] spike_bus,
  output logic                                      networkDone,
  output logic                                      busy,
  output logic [15:0]                               round_cnt
);

  net_state_e                                state_q;
  logic [NEURON_ID_WIDTH-1:0]                idx_q, steps_q, ptr_q, act_q;
  logic [TEN_DATA_WIDTH+NEURON_ID_WIDTH-1:0] spike_bus_q;
  logic                                      done_q, busy_q;
  logic [15:0]                               round_q;

  logic                       all_ready;
  logic [TEN_DATA_WIDTH-1:0]  code;
  logic                       fire;
  logic [NEURON_ID_WIDTH-1:0] idx_plus, idx_wrap;

  ready_reducer #(
    .NUM_NEURON     (NUM_NEURON),
    .NEURON_ID_WIDTH(NEURON_ID_WIDTH)
  ) u_ready (
    .en_network_vec_i(en_network_vec),
    .active_neuron_i (active_neuron),
    .all_ready_o     (all_ready)
  );

  // Code 11 falls through as "no spike" because fire only accepts POS/NEG.
  always_comb begin
    code = SPK_NONE;
    if (int'(idx_q) < NUM_NEURON) begin
      code = spike_vec[TEN_DATA_WIDTH*idx_q +: TEN_DATA_WIDTH];
    end
    fire     = (code == SPK_POS) || (code == SPK_NEG);
    idx_plus = idx_q + 1'b1;
    idx_wrap = (idx_plus == act_q) ? '0 : idx_plus;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      steps_q     <= '0;
      ptr_q       <= '0;
      act_q       <= '0;
      spike_bus_q <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      round_q     <= '0;
    end else if (en) begin
      unique case (state_q)
        ST_IDLE: begin
          if ((active_neuron != '0) && all_ready) begin
            state_q <= ST_SCAN;
            busy_q  <= 1'b1;
            act_q   <= active_neuron;
            idx_q   <= (ptr_q >= active_neuron) ? '0 : ptr_q;
            steps_q <= '0;
          end
        end
        ST_SCAN: begin
          if (fire) begin
            spike_bus_q <= {code, idx_q};
            ptr_q       <= idx_wrap;
            state_q     <= ST_DONE;
            done_q      <= 1'b1;
            round_q     <= round_q + 16'd1;
          end else if (steps_q == act_q - 1'b1) begin
            // Full lap without a spike: report the last index, keep the pointer.
            spike_bus_q <= {SPK_NONE, idx_q};
            state_q     <= ST_DONE;
            done_q      <= 1'b1;
            round_q     <= round_q + 16'd1;
          end else begin
            idx_q   <= idx_wrap;
            steps_q <= steps_q + 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign spike_bus   = spike_bus_q;
  assign networkDone = done_q;
  assign busy        = busy_q;
  assign round_cnt   = round_q;

endmodule

// File: tb/tb_spike_network.sv
// Directed bench for spike_network: round-robin rounds, gating, stalls and reset mid-scan.
module tb_spike_network;

  localparam int DW = 2;
  localparam int NN = 512;
  localparam int IW = 9;

  logic              clk = 1'b0;
  logic              reset;
  logic              en;
  logic [IW-1:0]     active_neuron;
  logic [NN-1:0]     en_network_vec;
  logic [DW*NN-1:0]  spike_vec;
  logic [DW+IW-1:0]  spike_bus;
  logic              networkDone;
  logic              busy;
  logic [15:0]       round_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  spike_network #(
    .TEN_DATA_WIDTH (DW),
    .NUM_NEURON     (NN),
    .NEURON_ID_WIDTH(IW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .en            (en),
    .active_neuron (active_neuron),
    .en_network_vec(en_network_vec),
    .spike_vec     (spike_vec),
    .spike_bus     (spike_bus),
    .networkDone   (networkDone),
    .busy          (busy),
    .round_cnt     (round_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise all requests, optionally stall en for `stall` cycles in the first scan cycle,
  // then count cycles from the trigger cycle T to the networkDone cycle.
  task automatic do_round(input string tag, input int stall, input int exp_lat,
                          input logic [DW+IW-1:0] exp_bus, input logic [15:0] exp_rc,
                          input logic [IW-1:0] exp_ptr);
    int lat;
    en_network_vec = '1;
    tick();
    lat = 1;
    chk({tag, ".busy_start"}, 32'(busy), 32'd1);
    if (stall > 0) begin
      en = 1'b0;
      for (int s = 0; s < stall; s++) begin
        tick();
        lat++;
      end
      chk({tag, ".busy_stall"}, 32'(busy), 32'd1);
      en = 1'b1;
    end
    while (!networkDone && lat < 700) begin
      tick();
      lat++;
    end
    en_network_vec = '0;
    chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".spike_bus"}, 32'(spike_bus), 32'(exp_bus));
    chk({tag, ".round_cnt"}, 32'(round_cnt), 32'(exp_rc));
    chk({tag, ".ptr"}, 32'(dut.ptr_q), 32'(exp_ptr));
    tick();
    chk({tag, ".done_one_cycle"}, 32'(networkDone), 32'd0);
    chk({tag, ".busy_end"}, 32'(busy), 32'd0);
    chk({tag, ".bus_hold"}, 32'(spike_bus), 32'(exp_bus));
  endtask

  initial begin
    int seen;
    reset          = 1'b1;
    en             = 1'b1;
    active_neuron  = '0;
    en_network_vec = '0;
    spike_vec      = '0;
    tick();
    tick();
    chk("rst.spike_bus", 32'(spike_bus), 32'd0);
    chk("rst.done", 32'(networkDone), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.round_cnt", 32'(round_cnt), 32'd0);
    reset = 1'b0;
    tick();

    // Round 1: neuron 2 fires positive, scan 0,1,2.
    active_neuron = 9'd4;
    spike_vec     = '0;
    spike_vec[5:4] = 2'b01;
    do_round("r1", 0, 4, {2'b01, 9'd2}, 16'd1, 9'd3);
    tick(); tick(); tick();

    // Round 2: neurons 0 and 2 fire negative, ptr=3 -> scan 3,0.
    spike_vec      = '0;
    spike_vec[1:0] = 2'b10;
    spike_vec[5:4] = 2'b10;
    do_round("r2", 0, 3, {2'b10, 9'd0}, 16'd2, 9'd1);
    tick(); tick(); tick();

    // Round 3: no spikes, full lap 1,2,3,0.
    spike_vec = '0;
    do_round("r3", 0, 5, {2'b00, 9'd0}, 16'd3, 9'd1);
    tick(); tick(); tick();

    // Neuron 3 holds off the round; code 11 at neuron 1 is skipped.
    spike_vec      = '0;
    spike_vec[3:2] = 2'b11;
    spike_vec[7:6] = 2'b01;
    en_network_vec = '0;
    en_network_vec[2:0] = 3'b111;
    tick(); tick(); tick();
    chk("gate.busy", 32'(busy), 32'd0);
    chk("gate.round_cnt", 32'(round_cnt), 32'd3);
    do_round("r4", 0, 4, {2'b01, 9'd3}, 16'd4, 9'd0);
    tick(); tick(); tick();

    // active_neuron = 0 never leaves IDLE.
    active_neuron  = '0;
    en_network_vec = '1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (busy || networkDone) seen++;
    end
    en_network_vec = '0;
    chk("zero_active.activity", 32'(seen), 32'd0);
    chk("zero_active.round_cnt", 32'(round_cnt), 32'd4);
    tick(); tick(); tick();

    // 3-cycle en stall mid-scan: neuron 3 fires, ptr=0 -> normally T+5, now T+8.
    active_neuron  = 9'd4;
    spike_vec      = '0;
    spike_vec[7:6] = 2'b10;
    do_round("r5_stall", 3, 8, {2'b10, 9'd3}, 16'd5, 9'd0);
    tick(); tick(); tick();

    // Reset in SCAN: outputs return to reset values, no release pulse.
    spike_vec      = '0;
    en_network_vec = '1;
    tick();
    tick();
    chk("rst_scan.busy_before", 32'(busy), 32'd1);
    reset          = 1'b1;
    en_network_vec = '0;
    tick();
    chk("rst_scan.spike_bus", 32'(spike_bus), 32'd0);
    chk("rst_scan.busy", 32'(busy), 32'd0);
    chk("rst_scan.round_cnt", 32'(round_cnt), 32'd0);
    chk("rst_scan.done", 32'(networkDone), 32'd0);
    reset = 1'b0;
    seen  = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (networkDone) seen++;
    end
    chk("rst_scan.no_pulse", 32'(seen), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
